// File: rtl/dtw_pkg.sv
// rtl/dtw_pkg.sv - shared constants for the DTW memory access path
package dtw_pkg;

    localparam int ADDR_W    = 10;
    localparam int DATA_W    = 32;
    localparam int MEM_WORDS = 1024;
    localparam int RES_BASE  = 20;

    localparam logic OP_RD     = 1'b0;
    localparam logic OP_WR     = 1'b1;
    localparam logic CS_ACTIVE = 1'b0;
    localparam logic CS_IDLE   = 1'b1;

endpackage

// File: rtl/dtw_mem_ctrl.sv
// rtl/dtw_mem_ctrl.sv - valid/ready to single-port synchronous memory bridge
module dtw_mem_ctrl #(
    parameter int ADDR_W = dtw_pkg::ADDR_W,
    parameter int DATA_W = dtw_pkg::DATA_W
) (
    input  logic              clk,
    input  logic              nrst,
    input  logic              req_valid,
    output logic              req_ready,
    input  logic              req_we,
    input  logic [ADDR_W-1:0] req_addr,
    input  logic [DATA_W-1:0] req_wdata,
    output logic              rsp_valid,
    output logic [DATA_W-1:0] rsp_rdata,
    output logic              busy,
    output logic [ADDR_W-1:0] mem_addr,
    inout  wire  [DATA_W-1:0] mem_data,
    output logic              mem_WR,
    output logic              mem_CS
);
    import dtw_pkg::*;

    logic              iss_valid;
    logic              iss_we;
    logic              cap;
    logic              drive_en;
    logic [DATA_W-1:0] wdata_q;
    logic              read_issue;
    logic              accept;

    // A read is on the bus this cycle, so next cycle is its capture cycle
    assign read_issue = iss_valid & (iss_we == OP_RD);

    // Writes must wait out the capture cycle of a read; reads never stall
    assign req_ready  = nrst & ~((req_we == OP_WR) & read_issue);
    assign accept     = req_valid & req_ready;
    assign busy       = iss_valid | cap;

    // Only the write issue cycle drives the shared bus
    assign mem_data   = drive_en ? wdata_q : {DATA_W{1'bz}};

    // Issue stage, capture flag, registered memory pins and response
    always_ff @(posedge clk or negedge nrst) begin
        if (!nrst) begin
            iss_valid <= 1'b0;
            iss_we    <= OP_RD;
            cap       <= 1'b0;
            rsp_valid <= 1'b0;
            rsp_rdata <= '0;
            mem_CS    <= CS_IDLE;
            mem_WR    <= 1'b0;
            mem_addr  <= '0;
            drive_en  <= 1'b0;
            wdata_q   <= '0;
        end else begin
            iss_valid <= accept;
            iss_we    <= req_we;
            cap       <= read_issue;
            rsp_valid <= cap;
            if (cap) begin
                rsp_rdata <= mem_data;
            end
            if (accept) begin
                mem_CS   <= CS_ACTIVE;
                mem_WR   <= req_we;
                mem_addr <= req_addr;
                drive_en <= (req_we == OP_WR);
                wdata_q  <= req_wdata;
            end else begin
                // Hold CS low with WR low after a read so the data is captured
                mem_CS   <= read_issue ? CS_ACTIVE : CS_IDLE;
                mem_WR   <= 1'b0;
                drive_en <= 1'b0;
            end
        end
    end

endmodule

// File: tb/tb_dtw_mem_ctrl.sv
// tb/tb_dtw_mem_ctrl.sv - self-checking bench for dtw_mem_ctrl
module tb_dtw_mem_ctrl;
    import dtw_pkg::*;

    logic        clk = 1'b0;
    logic        nrst = 1'b0;
    logic        req_valid = 1'b0;
    logic        req_we = 1'b0;
    logic [9:0]  req_addr = '0;
    logic [31:0] req_wdata = '0;
    logic        req_ready;
    logic        rsp_valid;
    logic [31:0] rsp_rdata;
    logic        busy;
    logic [9:0]  mem_addr;
    wire  [31:0] mem_data;
    logic        mem_WR;
    logic        mem_CS;

    int checks = 0;
    int errors = 0;
    logic [31:0] zval = {32{1'bz}};

    always #5 clk = ~clk;

    dtw_mem_ctrl dut (
        .clk(clk), .nrst(nrst), .req_valid(req_valid), .req_ready(req_ready),
        .req_we(req_we), .req_addr(req_addr), .req_wdata(req_wdata),
        .rsp_valid(rsp_valid), .rsp_rdata(rsp_rdata), .busy(busy),
        .mem_addr(mem_addr), .mem_data(mem_data), .mem_WR(mem_WR), .mem_CS(mem_CS)
    );

    // External memory model: write stores at edge, read drives next cycle while CS=0,WR=0
    logic [31:0] tb_mem [0:1023];
    logic [31:0] ref_mem [0:1023];
    logic        rd_pend = 1'b0;
    logic [31:0] rd_q = '0;
    wire         mem_drv = rd_pend & !mem_CS & !mem_WR;
    assign mem_data = mem_drv ? rd_q : {32{1'bz}};

    always @(posedge clk) begin
        if (!mem_CS && mem_WR) tb_mem[mem_addr] <= mem_data;
        rd_pend <= !mem_CS && !mem_WR;
        rd_q    <= tb_mem[mem_addr];
    end

    // Reference model: accepted-op history and expected response queue
    typedef struct { logic [31:0] data; int due; } exp_t;
    exp_t q[$];
    int cyc = 0;
    logic a1_v = 0, a1_we = 0, a2_v = 0, a2_we = 0;
    logic [9:0]  a1_addr = '0;
    logic [31:0] a1_d = '0;

    always @(posedge clk) begin
        cyc++;
        if (!nrst) begin
            q.delete(); a1_v = 0; a2_v = 0;
        end else begin
            a2_v = a1_v; a2_we = a1_we;
            a1_v = req_valid && req_ready;
            a1_we = req_we; a1_addr = req_addr; a1_d = req_wdata;
            if (a1_v) begin
                if (req_we) ref_mem[req_addr] = req_wdata;
                else q.push_back('{ref_mem[req_addr], cyc + 2});
            end
        end
    end

    always @(negedge nrst) begin
        q.delete(); a1_v = 0; a2_v = 0;
    end

    // Per-cycle protocol monitor against the reference model
    always @(negedge clk) begin
        #2;
        if (nrst) begin
            logic exp_cs, exp_wr;
            exp_t e;
            exp_cs = !(a1_v || (a2_v && !a2_we));
            exp_wr = a1_v && a1_we;
            if (req_valid) begin
                checks++;
                if (req_ready !== !(req_we && a1_v && !a1_we)) begin
                    errors++; $display("FAIL req_ready: got %b expected %b", req_ready, !(req_we && a1_v && !a1_we));
                end
            end
            checks++;
            if (mem_CS !== exp_cs || mem_WR !== exp_wr || busy !== !exp_cs) begin
                errors++; $display("FAIL pins: got cs=%b wr=%b busy=%b expected cs=%b wr=%b busy=%b", mem_CS, mem_WR, busy, exp_cs, exp_wr, !exp_cs);
            end
            if (a1_v) begin
                checks++;
                if (mem_addr !== a1_addr) begin
                    errors++; $display("FAIL mem_addr: got %h expected %h", mem_addr, a1_addr);
                end
            end
            checks++;
            if (exp_wr) begin
                if (mem_data !== a1_d) begin
                    errors++; $display("FAIL bus_write: got %h expected %h", mem_data, a1_d);
                end
            end else if (!mem_drv) begin
                if (mem_data !== zval) begin
                    errors++; $display("FAIL bus_release: got %h expected z", mem_data);
                end
            end else if ($isunknown(mem_data)) begin
                errors++; $display("FAIL bus_x: got %h expected known data", mem_data);
            end
            if (rsp_valid) begin
                checks++;
                if (q.size() == 0) begin
                    errors++; $display("FAIL rsp_unexpected: got rsp %h expected none", rsp_rdata);
                end else begin
                    e = q.pop_front();
                    if (rsp_rdata !== e.data || cyc != e.due) begin
                        errors++; $display("FAIL rsp: got %h at %0d expected %h at %0d", rsp_rdata, cyc, e.data, e.due);
                    end
                end
            end else if (q.size() != 0 && q[0].due <= cyc) begin
                checks++; errors++;
                $display("FAIL rsp_missing: got none expected %h at %0d", q[0].data, q[0].due);
                void'(q.pop_front());
            end
        end
    end

    task automatic preload(input int a, input logic [31:0] v);
        tb_mem[a] <= v;
        ref_mem[a] = v;
    endtask

    task automatic send(input logic we, input logic [9:0] a, input logic [31:0] d, output int stalls);
        logic acc;
        stalls = 0;
        @(negedge clk);
        req_valid = 1'b1; req_we = we; req_addr = a; req_wdata = d;
        for (int i = 0; i < 20; i++) begin
            #1 acc = req_ready;
            @(posedge clk);
            if (acc) return;
            stalls++;
            @(negedge clk);
        end
        checks++; errors++;
        $display("FAIL send_timeout: got no accept expected accept within 20 cycles");
    endtask

    task automatic go_idle();
        @(negedge clk);
        req_valid = 1'b0; req_we = 1'b0;
    endtask

    task automatic test_reset();
        req_valid = 1'b1;
        @(negedge clk); #3;
        checks++;
        if (mem_CS !== 1'b1 || mem_WR !== 1'b0 || mem_addr !== 10'd0 || rsp_valid !== 1'b0 ||
            rsp_rdata !== 32'd0 || busy !== 1'b0 || req_ready !== 1'b0 || mem_data !== zval) begin
            errors++;
            $display("FAIL reset: got cs=%b wr=%b addr=%h rv=%b rd=%h busy=%b rdy=%b bus=%h expected 1 0 0 0 0 0 0 z",
                     mem_CS, mem_WR, mem_addr, rsp_valid, rsp_rdata, busy, req_ready, mem_data);
        end
        req_valid = 1'b0;
        @(negedge clk); nrst = 1'b1;
    endtask

    task automatic test_idle();
        for (int i = 0; i < 10; i++) begin
            @(negedge clk); #3;
            checks++;
            if (mem_CS !== 1'b1 || busy !== 1'b0 || rsp_valid !== 1'b0) begin
                errors++; $display("FAIL idle: got cs=%b busy=%b rv=%b expected 1 0 0", mem_CS, busy, rsp_valid);
            end
        end
    endtask

    task automatic test_single_read();
        int s;
        preload(5, 32'hDEADBEEF);
        send(OP_RD, 10'd5, 32'h0, s);
        for (int i = 1; i <= 4; i++) begin
            @(negedge clk);
            req_valid = 1'b0;
            #3;
            checks++;
            if (mem_CS !== (i > 2) || rsp_valid !== (i == 3) || (i == 3 && rsp_rdata !== 32'hDEADBEEF)) begin
                errors++; $display("FAIL single_read c%0d: got cs=%b rv=%b rd=%h expected cs=%b rv=%b rd=deadbeef",
                                   i, mem_CS, rsp_valid, rsp_rdata, i > 2, i == 3);
            end
        end
    endtask

    task automatic collect(input int n, output logic [31:0] got[$]);
        got.delete();
        for (int i = 0; i < n; i++) begin
            @(negedge clk); #3;
            if (rsp_valid) got.push_back(rsp_rdata);
        end
    endtask

    task automatic test_write_read();
        int s1, s2;
        logic [31:0] got[$];
        send(OP_WR, 10'(RES_BASE), 32'h12345678, s1);
        send(OP_RD, 10'(RES_BASE), 32'h0, s2);
        go_idle();
        collect(4, got);
        checks++;
        if (s1 != 0 || s2 != 0 || got.size() != 1 || got[0] !== 32'h12345678) begin
            errors++; $display("FAIL write_read: got stalls=%0d/%0d n=%0d expected 0/0 1 rsp 12345678", s1, s2, got.size());
        end
    endtask

    task automatic test_back_to_back();
        int s, tot;
        logic [31:0] got[$];
        tot = 0;
        for (int i = 0; i < 3; i++) preload(i, 32'hA0 + i);
        @(posedge clk);
        for (int i = 0; i < 3; i++) begin
            send(OP_RD, 10'(i), 32'h0, s); tot += s;
        end
        collect(3, got);
        req_valid = 1'b0;
        checks++;
        if (tot != 0 || got.size() != 3) begin
            errors++; $display("FAIL b2b_count: got stalls=%0d rsps=%0d expected 0 3", tot, got.size());
        end else begin
            for (int i = 0; i < 3; i++) begin
                checks++;
                if (got[i] !== 32'hA0 + i) begin
                    errors++; $display("FAIL b2b_data%0d: got %h expected %h", i, got[i], 32'hA0 + i);
                end
            end
        end
    endtask

    task automatic test_rd_wr_turnaround();
        int s1, s2;
        preload(3, 32'h33);
        preload(4, 32'h0);
        @(posedge clk);
        send(OP_RD, 10'd3, 32'h0, s1);
        send(OP_WR, 10'd4, 32'h55, s2);
        @(negedge clk);
        req_valid = 1'b0;
        #3;
        checks++;
        if (s2 != 1 || rsp_valid !== 1'b1 || rsp_rdata !== 32'h33) begin
            errors++; $display("FAIL turnaround: got stalls=%0d rv=%b rd=%h expected 1 1 33", s2, rsp_valid, rsp_rdata);
        end
        repeat (3) @(posedge clk);
        checks++;
        if (tb_mem[4] !== 32'h55) begin
            errors++; $display("FAIL turnaround_mem: got %h expected 55", tb_mem[4]);
        end
    endtask

    task automatic test_reset_mid();
        int s;
        send(OP_RD, 10'd7, 32'h0, s);
        #1 nrst = 1'b0;
        req_valid = 1'b0;
        #1;
        checks++;
        if (mem_CS !== 1'b1 || mem_data !== zval || busy !== 1'b0) begin
            errors++; $display("FAIL reset_mid: got cs=%b bus=%h busy=%b expected 1 z 0", mem_CS, mem_data, busy);
        end
        @(negedge clk); nrst = 1'b1;
        for (int i = 0; i < 6; i++) begin
            @(negedge clk); #3;
            checks++;
            if (rsp_valid !== 1'b0 || busy !== 1'b0) begin
                errors++; $display("FAIL reset_mid_after: got rv=%b busy=%b expected 0 0", rsp_valid, busy);
            end
        end
    endtask

    task automatic test_random();
        int s;
        for (int i = 0; i < 300; i++) begin
            if ($urandom_range(0, 3) == 0) begin
                go_idle();
                req_we = 1'($urandom);
                @(posedge clk);
            end else begin
                send(1'($urandom), 10'($urandom_range(0, 15)), $urandom, s);
            end
        end
        go_idle();
        repeat (5) @(posedge clk);
        for (int a = 0; a < 16; a++) begin
            checks++;
            if (tb_mem[a] !== ref_mem[a]) begin
                errors++; $display("FAIL random_mem[%0d]: got %h expected %h", a, tb_mem[a], ref_mem[a]);
            end
        end
    endtask

    initial begin
        for (int a = 0; a < 1024; a++) begin
            tb_mem[a] <= 32'h0;
            ref_mem[a] = 32'h0;
        end
        test_reset();
        test_idle();
        test_single_read();
        test_write_read();
        test_back_to_back();
        test_rd_wr_turnaround();
        test_reset_mid();
        test_random();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
